alu_arbiter: RTL and testbench

//  Shares the single 32-bit ALU between two requesters (r0, r1), e.g. the EX stage and a

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu.sv | 31 +++
 rtl/alu_arb_pick.sv | 81 ++++++++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Purpose : shared ALU opcodes, word type and requester indices for the ALU arbiter slice.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package alu_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    // ALU opcodes; 011 and 101 are unassigned and yield 0.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Requester indices into the per-port vectors.
    localparam int REQ_R0 = 0;
    localparam int REQ_R1 = 1;

    // Per-cycle arbitration decision; no lock is held across cycles.
    typedef enum logic [1:0] {
        ARB_NONE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Purpose : 32-bit combinational ALU (and/or/add/sll/sub/slt) with zero flag.
// Latency : combinational, 0 cycles.
// Backpr. : none; pure function of its inputs.
// Ports   : op[2:0] opcode, in1/in2 operands, out result, zero = (out == 0).
module alu
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  word_t      in1,
    input  word_t      in2,
    output word_t      out,
    output logic       zero
);

    always_comb begin
        out = '0;
        case (op)
            ALU_AND: out = in1 & in2;
            ALU_OR:  out = in1 | in2;
            ALU_ADD: out = in1 + in2;
            // Shift amount comes from in1, value from in2.
            ALU_SLL: out = in2 << in1[4:0];
            ALU_SUB: out = in1 - in2;
            ALU_SLT: out = {{(WORD_W-1){1'b0}}, ($signed(in1) < $signed(in2))};
            default: out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/alu_arb_pick.sv
// Purpose : picks at most one of two eligible requesters per cycle for the shared ALU.
// Latency : grant is combinational from eligibility; last_grant/starve_cnt update on the edge.
// Backpr. : a requester is only considered when eligible (its response slot can take a result).
// Ports   : elig0/elig1 eligibility in, grant[1:0] one-hot out, last_grant / starve_cnt state out.
// Config  : ALU_ARB_RR_EN defined -> round-robin on conflict; undefined -> r0 priority with r1 aging.
//           STARVE_LIMIT must be < 2**CNT_W so the counter can reach it.
module alu_arb_pick
    import alu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             elig0,
    input  logic             elig1,
    output logic [1:0]       grant,
    output logic             last_grant,
    output logic [CNT_W-1:0] starve_cnt
);

    arb_state_e       state;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        state = ARB_NONE;
        // No grant is issued while reset is asserted.
        if (rst_n) begin
            if (elig0 && elig1) begin
`ifdef ALU_ARB_RR_EN
                state = last_grant_q ? ARB_GRANT0 : ARB_GRANT1;
`else
                state = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) ? ARB_GRANT1 : ARB_GRANT0;
`endif
            end else if (elig0) begin
                state = ARB_GRANT0;
            end else if (elig1) begin
                state = ARB_GRANT1;
            end
        end
    end

    assign grant = {state == ARB_GRANT1, state == ARB_GRANT0};

    always_comb begin
        last_grant_d = last_grant_q;
        if (state != ARB_NONE) begin
            last_grant_d = (state == ARB_GRANT1);
        end
    end

    always_comb begin
`ifdef ALU_ARB_RR_EN
        starve_cnt_d = '0;
`else
        starve_cnt_d = starve_cnt_q;
        if (!elig1 || state == ARB_GRANT1) begin
            starve_cnt_d = '0;
        end else if (state == ARB_GRANT0 && starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
            // r1 was eligible and lost to r0; saturate at the limit.
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            starve_cnt_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign last_grant = last_grant_q;
    assign starve_cnt = starve_cnt_q;

endmodule

// File: rtl/alu_arbiter.sv
// Purpose : shares one 32-bit ALU between requesters r0/r1, one op per cycle, one-entry response buffer each.
// Latency : accept in cycle N -> rK_rsp_valid with result in cycle N+1; back-to-back when rsp_ready held.
// Backpr. : rK_ready drops while rK's response slot is full and not being popped this cycle.
// Ports   : clk, rst_n (sync, active-low); per K in {0,1}: rK_valid/rK_ready/rK_op/rK_in1/rK_in2 request,
//           rK_rsp_valid/rK_rsp_ready/rK_rsp_out/rK_rsp_zero response.
// Config  : ALU_ARB_RR_EN selects round-robin conflict resolution; default is r0 priority with r1 aging.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [2:0] r0_op,
    input  word_t      r0_in1,
    input  word_t      r0_in2,
    output logic       r0_rsp_valid,
    input  logic       r0_rsp_ready,
    output word_t      r0_rsp_out,
    output logic       r0_rsp_zero,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [2:0] r1_op,
    input  word_t      r1_in1,
    input  word_t      r1_in2,
    output logic       r1_rsp_valid,
    input  logic       r1_rsp_ready,
    output word_t      r1_rsp_out,
    output logic       r1_rsp_zero
);

    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [1:0]       rsp_rdy;
    logic [1:0]       rsp_vld_q, rsp_vld_d;
    logic [1:0]       rsp_zero_q, rsp_zero_d;
    word_t            rsp_out_q [2];
    word_t            rsp_out_d [2];
    logic [2:0]       alu_op;
    word_t            alu_in1, alu_in2, alu_out;
    logic             alu_zero;
    logic             last_grant_unused;
    logic [CNT_W-1:0] starve_cnt_unused;

    assign rsp_rdy = {r1_rsp_ready, r0_rsp_ready};

    // A slot can take a new result if empty or being popped in the same cycle.
    assign elig[REQ_R0] = r0_valid & (~rsp_vld_q[REQ_R0] | r0_rsp_ready);
    assign elig[REQ_R1] = r1_valid & (~rsp_vld_q[REQ_R1] | r1_rsp_ready);

    alu_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .clk        (clk),
        .rst_n      (rst_n),
        .elig0      (elig[REQ_R0]),
        .elig1      (elig[REQ_R1]),
        .grant      (grant),
        .last_grant (last_grant_unused),
        .starve_cnt (starve_cnt_unused)
    );

    assign r0_ready = grant[REQ_R0];
    assign r1_ready = grant[REQ_R1];

    // ALU inputs are forced to zero when nobody is granted.
    always_comb begin
        alu_op  = '0;
        alu_in1 = '0;
        alu_in2 = '0;
        if (grant[REQ_R0]) begin
            alu_op  = r0_op;
            alu_in1 = r0_in1;
            alu_in2 = r0_in2;
        end else if (grant[REQ_R1]) begin
            alu_op  = r1_op;
            alu_in1 = r1_in1;
            alu_in2 = r1_in2;
        end
    end

    alu u_alu (
        .op   (alu_op),
        .in1  (alu_in1),
        .in2  (alu_in2),
        .out  (alu_out),
        .zero (alu_zero)
    );

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rsp_vld_d[k]  = rsp_vld_q[k];
            rsp_zero_d[k] = rsp_zero_q[k];
            rsp_out_d[k]  = rsp_out_q[k];
            if (grant[k]) begin
                rsp_vld_d[k]  = 1'b1;
                rsp_zero_d[k] = alu_zero;
                rsp_out_d[k]  = alu_out;
            end else if (rsp_rdy[k]) begin
                // Pop without refill: data left as-is, only valid drops.
                rsp_vld_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_vld_q    <= '0;
            rsp_zero_q   <= '0;
            rsp_out_q[0] <= '0;
            rsp_out_q[1] <= '0;
        end else begin
            rsp_vld_q    <= rsp_vld_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_out_q[0] <= rsp_out_d[0];
            rsp_out_q[1] <= rsp_out_d[1];
        end
    end

    assign r0_rsp_valid = rsp_vld_q[REQ_R0];
    assign r0_rsp_out   = rsp_out_q[REQ_R0];
    assign r0_rsp_zero  = rsp_zero_q[REQ_R0];
    assign r1_rsp_valid = rsp_vld_q[REQ_R1];
    assign r1_rsp_out   = rsp_out_q[REQ_R1];
    assign r1_rsp_zero  = rsp_zero_q[REQ_R1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : self-checking bench for alu_arbiter: directed vectors, arbitration corners, random traffic.
// Latency : expectations sampled on the falling edge; reference state advanced on the rising edge.
// Backpr. : drivers hold op/operands stable while valid and not yet accepted.
module tb_alu_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r1_valid;
    logic [2:0]  r0_op, r1_op;
    logic [31:0] r0_in1, r0_in2, r1_in1, r1_in2;
    logic        r0_rsp_ready, r1_rsp_ready;
    logic        r0_ready, r1_ready;
    logic        r0_rsp_valid, r1_rsp_valid;
    logic [31:0] r0_rsp_out, r1_rsp_out;
    logic        r0_rsp_zero, r1_rsp_zero;

    always #5 clk = ~clk;

    alu_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_in1(r0_in1), .r0_in2(r0_in2),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_out(r0_rsp_out), .r0_rsp_zero(r0_rsp_zero),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_in1(r1_in1), .r1_in2(r1_in2),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_out(r1_rsp_out), .r1_rsp_zero(r1_rsp_zero)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what each response slot should hold, who was granted last, r1's losing streak.
    logic [1:0]  mv;
    logic [31:0] mo [2];
    logic [1:0]  mz;
    logic        m_last;
    int          streak;
    logic [1:0]  m_acc;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        zero;
    } vec_t;
    vec_t vt [13];

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b100:  return b << (a % 32);
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] model_grant();
        logic e0, e1;
        e0 = r0_valid && (!mv[0] || r0_rsp_ready);
        e1 = r1_valid && (!mv[1] || r1_rsp_ready);
        if (!rst_n) return 2'b00;
        if (e0 && e1) begin
`ifdef ALU_ARB_RR_EN
            return m_last ? 2'b01 : 2'b10;
`else
            return (streak >= STARVE_LIMIT) ? 2'b10 : 2'b01;
`endif
        end
        if (e0) return 2'b01;
        if (e1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the reference, mid-cycle.
    task automatic look();
        logic [1:0] g;
        @(negedge clk);
        g = model_grant();
        chk("r0_ready", 32'(r0_ready), 32'(g[0]));
        chk("r1_ready", 32'(r1_ready), 32'(g[1]));
        chk("r0_rsp_valid", 32'(r0_rsp_valid), 32'(mv[0]));
        chk("r1_rsp_valid", 32'(r1_rsp_valid), 32'(mv[1]));
        if (mv[0]) begin
            chk("r0_rsp_out", r0_rsp_out, mo[0]);
            chk("r0_rsp_zero", 32'(r0_rsp_zero), 32'(mz[0]));
        end
        if (mv[1]) begin
            chk("r1_rsp_out", r1_rsp_out, mo[1]);
            chk("r1_rsp_zero", 32'(r1_rsp_zero), 32'(mz[1]));
        end
    endtask

    // Advance the reference across a rising edge, then leave 1 time unit for the drivers.
    task automatic tick();
        logic [1:0]  g;
        logic        e1;
        logic [31:0] res;
        @(posedge clk);
        g  = model_grant();
        e1 = r1_valid && (!mv[1] || r1_rsp_ready);
        if (!rst_n) begin
            mv = 2'b00; mo[0] = 32'd0; mo[1] = 32'd0; mz = 2'b00;
            m_last = 1'b1; streak = 0; m_acc = 2'b00;
        end else begin
            if (g[0]) begin
                res = alu_ref(r0_op, r0_in1, r0_in2);
                mv[0] = 1'b1; mo[0] = res; mz[0] = (res == 32'd0);
            end else if (r0_rsp_ready) begin
                mv[0] = 1'b0;
            end
            if (g[1]) begin
                res = alu_ref(r1_op, r1_in1, r1_in2);
                mv[1] = 1'b1; mo[1] = res; mz[1] = (res == 32'd0);
            end else if (r1_rsp_ready) begin
                mv[1] = 1'b0;
            end
            if (g != 2'b00) m_last = g[1];
`ifndef ALU_ARB_RR_EN
            if (e1 && g[0]) streak++;
            else streak = 0;
`endif
            m_acc = g;
        end
        #1;
    endtask

    task automatic rand_req(output logic v, output logic [2:0] op, output logic [31:0] a, output logic [31:0] b);
        v  = ($urandom_range(0, 3) != 0);
        op = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       begin a = $urandom_range(0, 8); b = $urandom_range(0, 8); end
            1:       begin a = $urandom; b = $urandom; end
            2:       begin a = 32'h8000_0000; b = 32'h7fff_ffff; end
            default: begin a = 32'hffff_ffff; b = $urandom_range(0, 3); end
        endcase
    endtask

    initial begin
        // op, in1, in2, expected out, expected zero
        vt[0]  = '{3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0};
        vt[1]  = '{3'b001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0};
        vt[2]  = '{3'b010, 32'd5,         32'd7,         32'd12,        1'b0};
        vt[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1};
        vt[4]  = '{3'b100, 32'd4,         32'd1,         32'd16,        1'b0};
        vt[5]  = '{3'b100, 32'd33,        32'd3,         32'd6,         1'b0};
        vt[6]  = '{3'b110, 32'd3,         32'd3,         32'd0,         1'b1};
        vt[7]  = '{3'b110, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0};
        vt[8]  = '{3'b111, 32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0};
        vt[9]  = '{3'b111, 32'd2,         32'hFFFF_FFFF, 32'd0,         1'b1};
        vt[10] = '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0};
        vt[11] = '{3'b011, 32'd9,         32'd9,         32'd0,         1'b1};
        vt[12] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1};

        mv = 2'b00; mo[0] = 32'd0; mo[1] = 32'd0; mz = 2'b00;
        m_last = 1'b1; streak = 0; m_acc = 2'b00;

        // Reset held two cycles with r0 requesting.
        rst_n = 1'b0;
        r0_valid = 1'b1; r0_op = 3'b010; r0_in1 = 32'd5; r0_in2 = 32'd7;
        r1_valid = 1'b0; r1_op = 3'b000; r1_in1 = 32'd0; r1_in2 = 32'd0;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        tick();
        look();
        chk("rst_r0_ready", 32'(r0_ready), 32'd0);
        chk("rst_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
        chk("rst_r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
        chk("rst_r0_rsp_out", r0_rsp_out, 32'd0);
        chk("rst_r1_rsp_zero", 32'(r1_rsp_zero), 32'd0);
        tick();
        look();
        chk("rst2_r0_ready", 32'(r0_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request: r0 add 5+7, result one cycle after accept.
        look();
        chk("single_accept", 32'(r0_ready), 32'd1);
        chk("single_r1_idle", 32'(r1_ready), 32'd0);
        tick();
        r0_valid = 1'b0;
        look();
        chk("single_valid", 32'(r0_rsp_valid), 32'd1);
        chk("single_out", r0_rsp_out, 32'd12);
        chk("single_zero", 32'(r0_rsp_zero), 32'd0);
        chk("single_r1_rsp", 32'(r1_rsp_valid), 32'd0);
        tick();

        // Vector table through each port in turn.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 13; i++) begin
                if (p == 0) begin
                    r0_valid = 1'b1; r0_op = vt[i].op; r0_in1 = vt[i].a; r0_in2 = vt[i].b;
                end else begin
                    r1_valid = 1'b1; r1_op = vt[i].op; r1_in1 = vt[i].a; r1_in2 = vt[i].b;
                end
                look();
                chk("vec_ready", 32'(p == 0 ? r0_ready : r1_ready), 32'd1);
                tick();
                r0_valid = 1'b0; r1_valid = 1'b0;
                look();
                chk("vec_out", p == 0 ? r0_rsp_out : r1_rsp_out, vt[i].out);
                chk("vec_zero", 32'(p == 0 ? r0_rsp_zero : r1_rsp_zero), 32'(vt[i].zero));
                tick();
            end
        end

        // Conflict: both requesting continuously, consumers always ready; last grant so far was r1.
        r0_valid = 1'b1; r0_op = 3'b010; r0_in1 = 32'd1; r0_in2 = 32'd1;
        r1_valid = 1'b1; r1_op = 3'b110; r1_in1 = 32'd3; r1_in2 = 32'd3;
        for (int i = 0; i < 10; i++) begin
            logic exp_r1, prev_r1;
`ifdef ALU_ARB_RR_EN
            exp_r1  = (i % 2 == 1);
            prev_r1 = (i > 0) && ((i - 1) % 2 == 1);
`else
            exp_r1  = (i == 4 || i == 9);
            prev_r1 = (i == 5);
`endif
            look();
            chk("conflict_r1", 32'(r1_ready), 32'(exp_r1));
            chk("conflict_r0", 32'(r0_ready), 32'(!exp_r1));
            if (prev_r1) begin
                chk("conflict_sub_out", r1_rsp_out, 32'd0);
                chk("conflict_sub_zero", 32'(r1_rsp_zero), 32'd1);
            end
            tick();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        look();
        tick();

        // Backpressure on r0: slt(-1,2) held while r1 keeps being served.
        r0_valid = 1'b1; r0_op = 3'b111; r0_in1 = 32'hFFFF_FFFF; r0_in2 = 32'd2;
        r0_rsp_ready = 1'b0;
        look();
        chk("bp_first_accept", 32'(r0_ready), 32'd1);
        tick();
        r0_op = 3'b010; r0_in1 = 32'd1; r0_in2 = 32'd1;
        r1_valid = 1'b1; r1_op = 3'b010; r1_in1 = 32'd10; r1_in2 = 32'd20;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("bp_r0_ready", 32'(r0_ready), 32'd0);
            chk("bp_hold_valid", 32'(r0_rsp_valid), 32'd1);
            chk("bp_hold_out", r0_rsp_out, 32'd1);
            chk("bp_r1_served", 32'(r1_ready), 32'd1);
            tick();
        end
        r0_rsp_ready = 1'b1;
        look();
        chk("bp_pop_refill", 32'(r0_ready), 32'd1);
        tick();
        r0_valid = 1'b0; r1_valid = 1'b0;
        look();
        chk("bp_refill_out", r0_rsp_out, 32'd2);
        chk("bp_refill_valid", 32'(r0_rsp_valid), 32'd1);
        tick();

        // Reset right after an r1 sll accept drops the response.
        r1_valid = 1'b1; r1_op = 3'b100; r1_in1 = 32'd4; r1_in2 = 32'd1;
        r1_rsp_ready = 1'b0;
        look();
        chk("midrst_accept", 32'(r1_ready), 32'd1);
        tick();
        rst_n = 1'b0; r1_valid = 1'b0;
        look();
        tick();
        for (int i = 0; i < 3; i++) begin
            look();
            chk("midrst_valid", 32'(r1_rsp_valid), 32'd0);
            chk("midrst_out", r1_rsp_out, 32'd0);
            tick();
        end
        rst_n = 1'b1; r1_rsp_ready = 1'b1;
        tick();

        // Random traffic against the reference, with occasional resets.
        for (int c = 0; c < 600; c++) begin
            if (!r0_valid || m_acc[0]) rand_req(r0_valid, r0_op, r0_in1, r0_in2);
            if (!r1_valid || m_acc[1]) rand_req(r1_valid, r1_op, r1_in1, r1_in2);
            r0_rsp_ready = ($urandom_range(0, 2) != 0);
            r1_rsp_ready = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 63) != 0);
            look();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
